// File: rtl/hdmi_mode_code_pkg.sv
// Shared constants and mode-code encoder for the HDMI reconfig word.
// Used by the transmitter and by the receiver's case table.
package hdmi_mode_code_pkg;

    // Mode field values, occupying code bits [6:2]
    localparam logic [4:0] MODE_480P = 5'b00000;
    localparam logic [4:0] MODE_288P = 5'b00001;
    localparam logic [4:0] MODE_576P = 5'b00010;
    localparam logic [4:0] MODE_240P = 5'b00100;
    localparam logic [4:0] MODE_480I = 5'b01000;
    localparam logic [4:0] MODE_576I = 5'b10000;

    // Output resolution selector, occupying code bits [1:0]
    typedef enum logic [1:0] {
        RES_1080P = 2'd0,
        RES_960P  = 2'd1,
        RES_480P  = 2'd2,
        RES_VGA   = 2'd3
    } res_sel_t;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_HOLDOFF = 2'd2
    } tx_state_t;

    // Interlace wins over lowres; PAL picks the 50 Hz variant
    function automatic logic [6:0] encode_mode(
        input logic       pal,
        input logic       interlaced,
        input logic       lowres,
        input logic [1:0] res
    );
        logic [4:0] mode;
        if (interlaced) begin
            mode = pal ? MODE_576I : MODE_480I;
        end else if (lowres) begin
            mode = pal ? MODE_288P : MODE_240P;
        end else begin
            mode = pal ? MODE_576P : MODE_480P;
        end
        return {mode, res};
    endfunction

endpackage

// File: rtl/hdmi_mode_code_tx_if.sv
// Mode inputs and reconfig word outputs of the mode code transmitter.
// master drives the video-mode inputs, slave is the transmitter.
interface hdmi_mode_code_tx_if;

    logic [1:0] res_sel;
    logic       is_pal;
    logic       is_interlaced;
    logic       is_lowres;
    logic       force_resend;
    logic [7:0] data_out;
    logic       strobe;
    logic       busy;

    modport master (
        output res_sel,
        output is_pal,
        output is_interlaced,
        output is_lowres,
        output force_resend,
        input  data_out,
        input  strobe,
        input  busy
    );

    modport slave (
        input  res_sel,
        input  is_pal,
        input  is_interlaced,
        input  is_lowres,
        input  force_resend,
        output data_out,
        output strobe,
        output busy
    );

endinterface

// File: rtl/hdmi_mode_code_encode.sv
// Combinational wrapper that turns registered mode flags into a code.
// Kept separate so the receiver side can reuse the same encoder.
module hdmi_mode_code_encode
    import hdmi_mode_code_pkg::*;
(
    input  logic       pal,
    input  logic       interlaced,
    input  logic       lowres,
    input  logic [1:0] res,
    output logic [6:0] code
);

    assign code = encode_mode(pal, interlaced, lowres, res);

endmodule

// File: rtl/hdmi_mode_code_tx.sv
// HDMI reconfig word transmitter: qualifies the mode code for stability,
// spaces updates by a holdoff and toggles bit 7 to force a resend.
module hdmi_mode_code_tx
    import hdmi_mode_code_pkg::*;
#(
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLDOFF_CYCLES = 256
) (
    input  logic                 clock,
    input  logic                 reset_n,
    hdmi_mode_code_tx_if.slave   bus
);

    localparam int QW = $clog2(STABLE_CYCLES) + 1;
    localparam int HW = $clog2(HOLDOFF_CYCLES) + 1;

    localparam logic [QW-1:0] Q_LAST = QW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF_CYCLES - 1);

    logic [1:0]  res_q;
    logic        pal_q;
    logic        il_q;
    logic        lr_q;
    logic [6:0]  cand;

    tx_state_t   state_q;
    tx_state_t   state_d;
    logic [7:0]  dout_q;
    logic [7:0]  dout_d;
    logic        strobe_q;
    logic        strobe_d;
    logic        pend_q;
    logic        pend_d;
    logic [6:0]  latch_q;
    logic [6:0]  latch_d;
    logic [QW-1:0] qcnt_q;
    logic [QW-1:0] qcnt_d;
    logic [HW-1:0] hcnt_q;
    logic [HW-1:0] hcnt_d;

    logic        cand_is_cur;
    logic        cand_is_latch;

    // Register the raw mode inputs once before encoding
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_q <= '0;
            pal_q <= 1'b0;
            il_q  <= 1'b0;
            lr_q  <= 1'b0;
        end else begin
            res_q <= bus.res_sel;
            pal_q <= bus.is_pal;
            il_q  <= bus.is_interlaced;
            lr_q  <= bus.is_lowres;
        end
    end

    hdmi_mode_code_encode u_encode (
        .pal        (pal_q),
        .interlaced (il_q),
        .lowres     (lr_q),
        .res        (res_q),
        .code       (cand)
    );

    assign cand_is_cur   = (cand == dout_q[6:0]);
    assign cand_is_latch = (cand == latch_q);

    // FSM, output word and counter state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            dout_q   <= 8'h00;
            strobe_q <= 1'b0;
            pend_q   <= 1'b0;
            latch_q  <= '0;
            qcnt_q   <= '0;
            hcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            strobe_q <= strobe_d;
            pend_q   <= pend_d;
            latch_q  <= latch_d;
            qcnt_q   <= qcnt_d;
            hcnt_q   <= hcnt_d;
        end
    end

    // Next-state logic: qualify new codes, toggle on resend, hold off
    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        strobe_d = 1'b0;
        pend_d   = pend_q;
        latch_d  = latch_q;
        qcnt_d   = qcnt_q;
        hcnt_d   = hcnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!cand_is_cur) begin
                    // The commit itself changes the word, so drop resends
                    latch_d = cand;
                    qcnt_d  = '0;
                    pend_d  = 1'b0;
                    state_d = ST_QUALIFY;
                end else if (bus.force_resend || pend_q) begin
                    dout_d   = {~dout_q[7], dout_q[6:0]};
                    strobe_d = 1'b1;
                    pend_d   = 1'b0;
                    hcnt_d   = '0;
                    state_d  = ST_HOLDOFF;
                end
            end
            ST_QUALIFY: begin
                if (bus.force_resend) begin
                    pend_d = 1'b1;
                end
                if (cand_is_cur) begin
                    state_d = ST_IDLE;
                end else if (!cand_is_latch) begin
                    latch_d = cand;
                    qcnt_d  = '0;
                end else if (qcnt_q == Q_LAST) begin
                    dout_d   = {dout_q[7], latch_q};
                    strobe_d = 1'b1;
                    hcnt_d   = '0;
                    state_d  = ST_HOLDOFF;
                end else begin
                    qcnt_d = qcnt_q + 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (bus.force_resend) begin
                    pend_d = 1'b1;
                end
                if (hcnt_q == H_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.data_out = dout_q;
    assign bus.strobe   = strobe_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hdmi_mode_code_tx.sv
// Scoreboard bench for hdmi_mode_code_tx with a timestamp-based model.
// Directed scenarios followed by randomized mode changes and resends.
module tb_hdmi_mode_code_tx;

    localparam int S = 4;
    localparam int H = 3;

    logic clock;
    logic reset_n;

    hdmi_mode_code_tx_if bus ();

    hdmi_mode_code_tx #(
        .STABLE_CYCLES  (S),
        .HOLDOFF_CYCLES (H)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad = 0;
    int nstrobe = 0;

    // model state
    int         m_cyc = 0;
    logic [7:0] m_out = 8'h00;
    bit         m_busy = 0;
    bit         m_pend = 0;
    int         q_code = -1;
    int         q_since = 0;
    int         hold_until = 0;
    bit         r_pal = 0;
    bit         r_il = 0;
    bit         r_lr = 0;
    int         r_res = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic fail(string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic int ref_code(bit pal, bit il, bit lr, int res);
        int base;
        if (il) base = pal ? 64 : 32;
        else if (lr) base = pal ? 4 : 16;
        else base = pal ? 8 : 0;
        return base + res;
    endfunction

    // Reference model: tracks qualify start and holdoff end as timestamps
    initial begin
        int  cand;
        bit  frc;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_cyc = 0;
                m_out = 8'h00;
                m_busy = 0;
                m_pend = 0;
                q_code = -1;
                q_since = 0;
                hold_until = 0;
                r_pal = 0;
                r_il = 0;
                r_lr = 0;
                r_res = 0;
                sb.delete();
            end else begin
                m_cyc++;
                cand = ref_code(r_pal, r_il, r_lr, r_res);
                frc = bus.force_resend;
                if (m_cyc < hold_until) begin
                    if (frc) m_pend = 1;
                end else if (q_code >= 0) begin
                    if (frc) m_pend = 1;
                    if (cand == int'(m_out[6:0])) begin
                        q_code = -1;
                    end else if (cand != q_code) begin
                        q_code = cand;
                        q_since = m_cyc;
                    end else if (m_cyc - q_since == S) begin
                        m_out[6:0] = cand[6:0];
                        sb.push_back('{m_cyc, m_out});
                        hold_until = m_cyc + H + 1;
                        q_code = -1;
                    end
                end else begin
                    if (cand != int'(m_out[6:0])) begin
                        q_code = cand;
                        q_since = m_cyc;
                        m_pend = 0;
                    end else if (frc || m_pend) begin
                        m_out[7] = ~m_out[7];
                        sb.push_back('{m_cyc, m_out});
                        m_pend = 0;
                        hold_until = m_cyc + H + 1;
                    end
                end
                r_pal = bus.is_pal;
                r_il = bus.is_interlaced;
                r_lr = bus.is_lowres;
                r_res = int'(bus.res_sel);
                m_busy = (q_code >= 0) || (m_cyc + 1 < hold_until);
            end
        end
    end

    // Monitor: pop expected words whenever the DUT strobes
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                check("rst_data_out", int'(bus.data_out), 0);
                check("rst_strobe", int'(bus.strobe), 0);
                check("rst_busy", int'(bus.busy), 0);
            end else begin
                check("busy", int'(bus.busy), int'(m_busy));
                check("data_out", int'(bus.data_out), int'(m_out));
                if (bus.strobe) begin
                    nstrobe++;
                    if (sb.size() == 0) begin
                        fail("unexpected_strobe");
                    end else begin
                        e = sb.pop_front();
                        check("strobe_cycle", m_cyc, e.cyc);
                        check("strobe_word", int'(bus.data_out), int'(e.val));
                    end
                end else if (sb.size() > 0 && sb[0].cyc <= m_cyc) begin
                    e = sb.pop_front();
                    fail("missed_strobe");
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic set_mode(bit pal, bit il, bit lr, logic [1:0] res);
        bus.is_pal = pal;
        bus.is_interlaced = il;
        bus.is_lowres = lr;
        bus.res_sel = res;
    endtask

    logic [4:0] seq [7] = '{5'b00100, 5'b11001, 5'b10111,
                            5'b01011, 5'b10001, 5'b00111, 5'b11010};

    initial begin
        int n0;
        reset_n = 1'b0;
        set_mode(0, 0, 0, 2'd0);
        bus.force_resend = 1'b0;
        tick(3);
        reset_n = 1'b1;

        // 1: idle after reset, then 480p -> 240p
        tick(8);
        check("t1_idle_word", int'(bus.data_out), 8'h00);
        check("t1_no_strobe", nstrobe, 0);
        set_mode(0, 0, 1, 2'd0);
        tick(5);
        check("t1_before_commit", int'(bus.data_out), 8'h00);
        tick(1);
        check("t1_commit", int'(bus.data_out), 8'h10);
        check("t1_one_strobe", nstrobe, 1);

        // 2: resolution change, then PAL, then interlaced overriding lowres
        tick(10);
        set_mode(0, 0, 1, 2'd2);
        tick(12);
        check("t2_res", int'(bus.data_out), 8'h12);
        set_mode(1, 0, 1, 2'd2);
        tick(12);
        check("t2_pal", int'(bus.data_out), 8'h06);
        set_mode(1, 1, 1, 2'd2);
        tick(12);
        check("t2_il", int'(bus.data_out), 8'h42);

        // 3: lowres glitch from 480p must not commit
        set_mode(0, 0, 0, 2'd0);
        tick(12);
        check("t3_base", int'(bus.data_out), 8'h00);
        n0 = nstrobe;
        bus.is_lowres = 1'b1;
        tick(2);
        bus.is_lowres = 1'b0;
        tick(10);
        check("t3_no_strobe", nstrobe, n0);
        check("t3_word", int'(bus.data_out), 8'h00);
        check("t3_idle", int'(bus.busy), 0);

        // 4: candidate churns every 3 cycles, then settles on 480i res 2
        n0 = nstrobe;
        for (int i = 0; i < 7; i++) begin
            set_mode(seq[i][4], seq[i][3], seq[i][2], seq[i][1:0]);
            tick(3);
        end
        set_mode(0, 1, 0, 2'd2);
        tick(15);
        check("t4_one_strobe", nstrobe - n0, 1);
        check("t4_word", int'(bus.data_out), 8'h22);

        // 5: resend toggles next edge; second resend waits out holdoff
        n0 = nstrobe;
        bus.force_resend = 1'b1;
        tick(1);
        check("t5_toggle", int'(bus.data_out), 8'hA2);
        bus.force_resend = 1'b0;
        tick(1);
        bus.force_resend = 1'b1;
        tick(1);
        bus.force_resend = 1'b0;
        tick(1);
        check("t5_held", int'(bus.data_out), 8'hA2);
        tick(1);
        check("t5_second", int'(bus.data_out), 8'h22);
        check("t5_two_strobes", nstrobe - n0, 2);

        // 6: reset in QUALIFY with a pending resend
        tick(8);
        set_mode(0, 0, 0, 2'd0);
        tick(2);
        check("t6_qualify", int'(bus.busy), 1);
        bus.force_resend = 1'b1;
        tick(1);
        bus.force_resend = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_word", int'(bus.data_out), 8'h00);
        check("t6_rst_busy", int'(bus.busy), 0);
        tick(2);
        reset_n = 1'b1;
        n0 = nstrobe;
        tick(15);
        check("t6_no_strobe", nstrobe, n0);
        check("t6_word", int'(bus.data_out), 8'h00);

        // random mode changes and resend pulses
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            end
            bus.force_resend = ($urandom_range(0, 7) == 0);
            tick(1);
            bus.force_resend = 1'b0;
            tick($urandom_range(0, 9));
        end
        tick(25);
        check("final_queue_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
